// File: rtl/axil_reg_master_arb.sv
// Two-requester round-robin AXI4-Lite master: each grant becomes one single-beat write or read.
// Define AXIL_ARB_VERIFY_EN to re-read every OKAY write and flag readback mismatches.
module axil_reg_master_arb #(
  parameter int         ADDR_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  output logic [1:0]          req_ack,
  output logic [31:0]         rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_mismatch,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [31:0]         m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [31:0]         m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
`ifdef AXIL_ARB_VERIFY_EN
  localparam logic [2:0] VADDR = 3'd5;
  localparam logic [2:0] VDATA = 3'd6;
`endif
  localparam logic [2:0] DONE  = 3'd7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  logic [2:0]        state_q;
  logic              last_q;
  logic              gnt_q;
  logic              gnt_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              aw_done;
  logic              w_done;

  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;
  assign m_axi_wstrb  = 4'hF;

  // Priority goes to the requester that was not served last.
  always_comb begin
    gnt_sel = ~last_q;
    if (!req_valid[~last_q])
      gnt_sel = last_q;
  end

  assign sel_we    = gnt_sel ? req_we[1] : req_we[0];
  assign sel_addr  = gnt_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = gnt_sel ? req_wdata[63:32] : req_wdata[31:0];

  // A channel is finished once its valid has dropped or its handshake happens now.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  assign req_ack = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_mismatch  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            gnt_q <= gnt_sel;
            if (sel_we) begin
              m_axi_awaddr  <= sel_addr;
              m_axi_wdata   <= sel_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state_q       <= WADDR;
            end else begin
              m_axi_araddr  <= sel_addr;
              m_axi_arvalid <= 1'b1;
              state_q       <= RADDR;
            end
          end
        end
        WADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state_q      <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_mismatch <= 1'b0;
            state_q      <= DONE;
`ifdef AXIL_ARB_VERIFY_EN
            // Successful writes are re-read from the same address before acknowledging.
            if (m_axi_bresp == RESP_OKAY) begin
              m_axi_araddr  <= m_axi_awaddr;
              m_axi_arvalid <= 1'b1;
              state_q       <= VADDR;
            end
`endif
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state_q       <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_mismatch <= 1'b0;
            state_q      <= DONE;
          end
        end
`ifdef AXIL_ARB_VERIFY_EN
        VADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state_q       <= VDATA;
          end
        end
        VDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            // An errored readback carries no meaningful data to compare.
            rsp_mismatch <= (m_axi_rresp == RESP_OKAY) && (m_axi_rdata != m_axi_wdata);
            state_q      <= DONE;
          end
        end
`endif
        DONE: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_master_arb.sv
// Bench for axil_reg_master_arb: behavioural AXI4-Lite slave, transaction-level
// expectation queue checked on every acknowledge, plus directed literal checks.
`timescale 1ns/1ps
module tb_axil_reg_master_arb;
  localparam int ADDR_W = 32;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic [1:0]  req_valid = '0, req_we = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_ack;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_mismatch;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axil_reg_master_arb #(.ADDR_W(ADDR_W), .PROT(3'b000)) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_mismatch(rsp_mismatch),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial forever #5 tb_ACLK = ~tb_ACLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  initial forever begin
    @(posedge tb_ACLK);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [16];
  int   cfg_aw_wait = 0, cfg_w_wait = 0, cfg_r_wait = 0;
  logic [1:0] cfg_bresp = 2'b00;
  bit   cfg_corrupt = 0;
  int   n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0;

  initial begin
    int aw_cnt, w_cnt, r_cnt;
    bit got_aw, got_w, b_due, b_fire, r_pend, r_fire;
    logic [3:0] r_idx;
    aw_cnt = 0; w_cnt = 0; r_cnt = 0; r_idx = '0;
    got_aw = 0; got_w = 0; b_due = 0; b_fire = 0; r_pend = 0; r_fire = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge tb_ACLK);
      if (!tb_ARESETN) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
        m_axi_rvalid = 0; got_aw = 0; got_w = 0; b_due = 0; b_fire = 0;
        r_pend = 0; r_fire = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (b_fire) begin m_axi_bvalid = 0; b_fire = 0; end
        if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; end
        if (b_due) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; b_due = 0; end
        if (r_pend) begin
          if (r_cnt == 0) begin
            m_axi_rvalid = 1; m_axi_rresp = 2'b00; r_pend = 0;
            m_axi_rdata = mem[r_idx] ^ {31'b0, cfg_corrupt};
          end else r_cnt--;
        end
        m_axi_awready = m_axi_awvalid && (aw_cnt >= cfg_aw_wait);
        if (m_axi_awvalid && m_axi_awready) begin
          n_aw++; got_aw = 1; aw_cnt = 0; last_awaddr = m_axi_awaddr;
        end else if (m_axi_awvalid) aw_cnt++;
        m_axi_wready = m_axi_wvalid && (w_cnt >= cfg_w_wait);
        if (m_axi_wvalid && m_axi_wready) begin
          n_w++; got_w = 1; w_cnt = 0; last_wdata = m_axi_wdata;
        end else if (m_axi_wvalid) w_cnt++;
        if (got_aw && got_w) begin
          got_aw = 0; got_w = 0; b_due = 1;
          if (cfg_bresp == 2'b00) mem[last_awaddr[5:2]] = last_wdata;
        end
        m_axi_arready = m_axi_arvalid;
        if (m_axi_arvalid) begin
          n_ar++; r_pend = 1; r_cnt = cfg_r_wait; r_idx = m_axi_araddr[5:2];
        end
        if (m_axi_bvalid && m_axi_bready) begin b_fire = 1; n_b++; end
        if (m_axi_rvalid && m_axi_rready) begin r_fire = 1; n_r++; end
      end
    end
  end

  // ---------------- transaction-level model ----------------
  typedef struct {
    bit          who;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          mm;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] model_mem [16];
  bit model_last = 1'b1;

  function automatic exp_t model_txn(bit who, bit we, logic [31:0] addr, logic [31:0] wd);
    exp_t e;
    e.who = who; e.rdata = '0; e.resp = 2'b00; e.mm = 0;
    if (!we) e.rdata = model_mem[addr[5:2]];
    else begin
      e.resp = cfg_bresp;
      if (cfg_bresp == 2'b00) begin
        model_mem[addr[5:2]] = wd;
`ifdef AXIL_ARB_VERIFY_EN
        e.rdata = wd ^ {31'b0, cfg_corrupt};
        e.mm = cfg_corrupt;
`endif
      end
    end
    model_last = who;
    return e;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    mem[addr[5:2]] = val;
    model_mem[addr[5:2]] = val;
  endtask

  // Compare process: every acknowledge is checked against the head of the expectation queue.
  initial begin
    logic [1:0] prev;
    exp_t e;
    prev = 2'b00;
    forever begin
      @(negedge tb_ACLK);
      if (tb_ARESETN && req_ack != 2'b00) begin
        check("ack_gap", {62'b0, prev}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got 0x%0h expected none", req_ack);
        end else begin
          e = exp_q.pop_front();
          check("ack_who", {62'b0, req_ack}, e.who ? 64'd2 : 64'd1);
          check("ack_rdata", {32'b0, rsp_rdata}, {32'b0, e.rdata});
          check("ack_resp", {62'b0, rsp_resp}, {62'b0, e.resp});
          check("ack_mismatch", {63'b0, rsp_mismatch}, {63'b0, e.mm});
        end
      end
      prev = tb_ARESETN ? req_ack : 2'b00;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit who, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit push, output int t0);
    @(negedge tb_ACLK);
    req_valid[who] = 1'b1;
    req_we[who] = we;
    req_addr[who*32 +: 32] = addr;
    req_wdata[who*32 +: 32] = wd;
    if (push) exp_q.push_back(model_txn(who, we, addr, wd));
    t0 = cyc;
  endtask

  task automatic wait_ack(input bit who, input int t0, output int lat,
                          output logic [31:0] rd, output logic [1:0] rs, output logic mm);
    lat = -1; rd = 'x; rs = 'x; mm = 'x;
    for (int n = 0; n < 60; n++) begin
      @(negedge tb_ACLK);
      if (req_ack[who]) begin
        lat = cyc - t0; rd = rsp_rdata; rs = rsp_resp; mm = rsp_mismatch;
        break;
      end
    end
    req_valid[who] = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack for requester %0d", who);
    end
  endtask

  localparam int WR_LAT =
`ifdef AXIL_ARB_VERIFY_EN
    5;
`else
    3;
`endif

  task automatic check_all_zero(input string name);
    check({name, "_valids"}, {59'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                              m_axi_arvalid, m_axi_rready}, 64'd0);
    check({name, "_ack"}, {62'b0, req_ack}, 64'd0);
    check({name, "_rsp"}, {29'b0, rsp_rdata, rsp_resp, rsp_mismatch}, 64'd0);
    check({name, "_addr"}, {m_axi_awaddr, m_axi_araddr}, 64'd0);
    check({name, "_wdata"}, {32'b0, m_axi_wdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, a0, b0, nack;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        mm;
    bit          order [4];
    logic [31:0] rd_seen [4];
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    // Reset state
    #1 check_all_zero("reset_async");
    repeat (3) @(negedge tb_ACLK);
    check_all_zero("reset");
    check("reset_wstrb", {60'b0, m_axi_wstrb}, 64'hF);
    tb_ARESETN = 1'b1;

    // Zero-wait write from requester 0
    issue(1'b0, 1'b1, 32'h0, 32'h0101FFFF, 1'b1, t0);
    @(negedge tb_ACLK);
    check("wr_c1_valids", {62'b0, m_axi_awvalid, m_axi_wvalid}, 64'd3);
    check("wr_c1_awaddr", {32'b0, m_axi_awaddr}, 64'h0);
    check("wr_c1_wdata", {32'b0, m_axi_wdata}, 64'h0101FFFF);
    wait_ack(1'b0, t0, lat, rd, rs, mm);
    check("wr_latency", lat, WR_LAT);
    check("wr_resp", {62'b0, rs}, 64'd0);
    check("wr_slave_data", {32'b0, last_wdata}, 64'h0101FFFF);
`ifdef AXIL_ARB_VERIFY_EN
    check("wr_rdata", {32'b0, rd}, 64'h0101FFFF);
`else
    check("wr_rdata", {32'b0, rd}, 64'h0);
`endif

    // Read from requester 1
    preload(32'h4, 32'hABCD0001);
    a0 = n_ar;
    issue(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, t0);
    wait_ack(1'b1, t0, lat, rd, rs, mm);
    check("rd_ar_count", n_ar - a0, 1);
    check("rd_rdata", {32'b0, rd}, 64'hABCD0001);
    check("rd_latency", lat, 3);

    // Both requesters hold req_valid: requester 0 writes, requester 1 reads same register
    @(negedge tb_ACLK);
    req_we = 2'b01;
    req_addr = {32'h10, 32'h10};
    req_wdata = {32'h0, 32'h5A5A0000};
    for (int k = 0; k < 4; k++)
      exp_q.push_back(model_txn(~model_last, model_last, 32'h10, 32'h5A5A0000));
    req_valid = 2'b11;
    nack = 0;
    for (int n = 0; n < 200 && nack < 4; n++) begin
      @(negedge tb_ACLK);
      if (req_ack != 2'b00) begin
        order[nack] = req_ack[1];
        rd_seen[nack] = rsp_rdata;
        nack++;
      end
    end
    req_valid = 2'b00;
    check("rr_ack_count", nack, 4);
    check("rr_order", {60'b0, order[0], order[1], order[2], order[3]}, 64'b0101);
    check("rr_read1", {32'b0, rd_seen[1]}, 64'h5A5A0000);
    check("rr_read3", {32'b0, rd_seen[3]}, 64'h5A5A0000);

    // W channel ready three cycles ahead of AW
    cfg_aw_wait = 3;
    b0 = n_b;
    issue(1'b0, 1'b1, 32'h14, 32'h00C0FFEE, 1'b1, t0);
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    check("split_c2_valids", {62'b0, m_axi_awvalid, m_axi_wvalid}, 64'b10);
    wait_ack(1'b0, t0, lat, rd, rs, mm);
    check("split_latency", lat, WR_LAT + 3);
    check("split_b_count", n_b - b0, 1);
    check("split_awaddr", {32'b0, last_awaddr}, 64'h14);
    cfg_aw_wait = 0;

    // Readback differs, then matches
    cfg_corrupt = 1;
    issue(1'b1, 1'b1, 32'h8, 32'hDEAD0011, 1'b1, t0);
    wait_ack(1'b1, t0, lat, rd, rs, mm);
    cfg_corrupt = 0;
`ifdef AXIL_ARB_VERIFY_EN
    check("vfy_bad_mm", {63'b0, mm}, 64'd1);
    check("vfy_bad_rdata", {32'b0, rd}, 64'hDEAD0010);
`else
    check("vfy_bad_mm", {63'b0, mm}, 64'd0);
    check("vfy_bad_rdata", {32'b0, rd}, 64'h0);
`endif
    issue(1'b0, 1'b1, 32'h8, 32'hDEAD0011, 1'b1, t0);
    wait_ack(1'b0, t0, lat, rd, rs, mm);
    check("vfy_ok_mm", {63'b0, mm}, 64'd0);

    // SLVERR on write: response forwarded, no readback
    cfg_bresp = 2'b10;
    a0 = n_ar;
    issue(1'b1, 1'b1, 32'hC, 32'h12345678, 1'b1, t0);
    wait_ack(1'b1, t0, lat, rd, rs, mm);
    cfg_bresp = 2'b00;
    check("err_resp", {62'b0, rs}, 64'b10);
    check("err_no_ar", n_ar - a0, 0);
    check("err_latency", lat, 3);
    issue(1'b0, 1'b0, 32'hC, 32'h0, 1'b1, t0);
    wait_ack(1'b0, t0, lat, rd, rs, mm);
    check("err_unwritten", {32'b0, rd}, 64'h0);

    // Reset asserted while waiting in RDATA
    cfg_r_wait = 5;
    issue(1'b0, 1'b0, 32'h4, 32'h0, 1'b0, t0);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge tb_ACLK);
      if (m_axi_rready) begin lat = n; break; end
    end
    check("rst_reached_rdata", {63'b0, m_axi_rready}, 64'd1);
    #2 tb_ARESETN = 1'b0;
    #1 check_all_zero("rst_mid");
    req_valid = 2'b00;
    cfg_r_wait = 0;
    repeat (2) @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    model_last = 1'b1;
    issue(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, t0);
    wait_ack(1'b1, t0, lat, rd, rs, mm);
    check("post_rst_rdata", {32'b0, rd}, 64'hABCD0001);
    check("post_rst_latency", lat, 3);
    repeat (3) @(negedge tb_ACLK);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
